// File: rtl/queue_ctrl.sv
// Control block for a RAM-backed circular queue: address/strobe generation,
// registered occupancy and status flags, and the E/D pair for an external up/down counter.
module queue_ctrl #(
    parameter int AW     = 10,
    parameter int AF_LVL = (1 << AW) - 4,
    parameter int AE_LVL = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic          cnt_e,
    output logic          cnt_d,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_MID   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   AF_THR  = (AW+1)'(AF_LVL);
    localparam logic [AW:0]   AE_THR  = (AW+1)'(AE_LVL);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [1:0]    r_state;
    logic          r_full;
    logic          r_empty;
    logic          r_almost_full;
    logic          r_almost_empty;
    logic          r_rd_valid;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_push_acc;
    logic          w_pop_acc;
    logic [AW:0]   w_count_nxt;
    logic [1:0]    w_state_nxt;
    logic          w_full_nxt;
    logic          w_empty_nxt;

    // Request acceptance; nothing is accepted while in reset or during a flush.
    always_comb begin
        w_pop_acc  = 1'b0;
        w_push_acc = 1'b0;
        if (reset_n && !clear) begin
            w_pop_acc  = pop & ~r_empty;
            // A full queue takes a push only when a pop frees a slot in the same cycle.
            w_push_acc = push & (~r_full | w_pop_acc);
        end else begin
            w_pop_acc  = 1'b0;
            w_push_acc = 1'b0;
        end
    end

    // Next occupancy: net of accepted push and pop, forced to zero by clear.
    always_comb begin
        w_count_nxt = r_count;
        if (clear) begin
            w_count_nxt = {(AW+1){1'b0}};
        end else if (w_push_acc && !w_pop_acc) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (w_pop_acc && !w_push_acc) begin
            w_count_nxt = r_count - CNT_ONE;
        end else begin
            w_count_nxt = r_count;
        end
    end

    // State follows the next occupancy; full/empty flags are decoded from it.
    always_comb begin
        w_state_nxt = S_MID;
        w_full_nxt  = 1'b0;
        w_empty_nxt = 1'b0;
        if (w_count_nxt == {(AW+1){1'b0}}) begin
            w_state_nxt = S_EMPTY;
        end else if (w_count_nxt == DEPTH) begin
            w_state_nxt = S_FULL;
        end else begin
            w_state_nxt = S_MID;
        end
        case (w_state_nxt)
            S_EMPTY: begin
                w_full_nxt  = 1'b0;
                w_empty_nxt = 1'b1;
            end
            S_FULL: begin
                w_full_nxt  = 1'b1;
                w_empty_nxt = 1'b0;
            end
            S_MID: begin
                w_full_nxt  = 1'b0;
                w_empty_nxt = 1'b0;
            end
            default: begin
                w_full_nxt  = 1'b0;
                w_empty_nxt = 1'b1;
            end
        endcase
    end

    // Pointers, occupancy, flags and one-cycle status pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr       <= {AW{1'b0}};
            r_rd_ptr       <= {AW{1'b0}};
            r_count        <= {(AW+1){1'b0}};
            r_state        <= S_EMPTY;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_rd_valid     <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (clear) begin
                r_wr_ptr <= {AW{1'b0}};
                r_rd_ptr <= {AW{1'b0}};
            end else begin
                r_wr_ptr <= w_push_acc ? r_wr_ptr + PTR_ONE : r_wr_ptr;
                r_rd_ptr <= w_pop_acc  ? r_rd_ptr + PTR_ONE : r_rd_ptr;
            end
            r_count        <= w_count_nxt;
            r_state        <= w_state_nxt;
            r_full         <= w_full_nxt;
            r_empty        <= w_empty_nxt;
            r_almost_full  <= (w_count_nxt >= AF_THR);
            r_almost_empty <= (w_count_nxt <= AE_THR);
            r_rd_valid     <= w_pop_acc;
            r_overflow     <= push & ~w_push_acc & ~clear;
            r_underflow    <= pop & ~w_pop_acc & ~clear;
        end
    end

    assign wr_en        = w_push_acc;
    assign rd_en        = w_pop_acc;
    assign wr_addr      = r_wr_ptr;
    assign rd_addr      = r_rd_ptr;
    assign cnt_e        = w_push_acc ^ w_pop_acc;
    assign cnt_d        = w_pop_acc & ~w_push_acc;
    assign count        = r_count;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign rd_valid     = r_rd_valid;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    queue_ctrl_chk #(.AW(AW)) u_chk (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .count   (r_count),
        .state   (r_state),
        .full    (r_full),
        .empty   (r_empty)
    );

endmodule

// Invariant checker for queue_ctrl: occupancy range, state/flag consistency, quiet flush.
module queue_ctrl_chk #(
    parameter int AW = 10
) (
    input logic        clk,
    input logic        reset_n,
    input logic        clear,
    input logic        wr_en,
    input logic        rd_en,
    input logic [AW:0] count,
    input logic [1:0]  state,
    input logic        full,
    input logic        empty
);

    localparam logic [1:0]  S_EMPTY = 2'd0;
    localparam logic [1:0]  S_FULL  = 2'd2;
    localparam logic [AW:0] DEPTH   = {1'b1, {AW{1'b0}}};

    a_count_range: assert property (@(posedge clk) disable iff (!reset_n)
        count <= DEPTH);
    a_full_flag: assert property (@(posedge clk) disable iff (!reset_n)
        full == (count == DEPTH));
    a_empty_flag: assert property (@(posedge clk) disable iff (!reset_n)
        empty == (count == {(AW+1){1'b0}}));
    a_state_empty: assert property (@(posedge clk) disable iff (!reset_n)
        (state == S_EMPTY) == empty);
    a_state_full: assert property (@(posedge clk) disable iff (!reset_n)
        (state == S_FULL) == full);
    a_clear_quiet: assert property (@(posedge clk) disable iff (!reset_n)
        clear |-> (!wr_en && !rd_en));

endmodule

// File: tb/tb_queue_ctrl.sv
// Bench for queue_ctrl (AW=2): queue-based reference model compared every cycle,
// plus directed sequences with hand-computed expectations.
module tb_queue_ctrl;

    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       clear = 1'b0;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic       rd_en;
    logic [1:0] rd_addr;
    logic       rd_valid;
    logic       cnt_e;
    logic       cnt_d;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    queue_ctrl #(.AW(AW), .AF_LVL(AF), .AE_LVL(AE)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .push         (push),
        .pop          (pop),
        .clear        (clear),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_valid     (rd_valid),
        .cnt_e        (cnt_e),
        .cnt_d        (cnt_d),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    // Reference model: the queue holds the RAM address each stored entry was written to.
    int m_q[$];
    int m_wr  = 0;
    int m_rd  = 0;
    bit m_rdv = 1'b0;
    bit m_ovf = 1'b0;
    bit m_udf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit f_pop_ok();
        return reset_n && !clear && pop && (m_q.size() > 0);
    endfunction

    function automatic bit f_push_ok();
        return reset_n && !clear && push && ((m_q.size() < DEPTH) || f_pop_ok());
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_wr  = 0;
            m_rd  = 0;
            m_rdv = 1'b0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            bit pa;
            bit wa;
            pa = f_pop_ok();
            wa = f_push_ok();
            m_rdv = pa;
            m_ovf = push && !wa && !clear;
            m_udf = pop && !pa && !clear;
            if (clear) begin
                m_q.delete();
                m_wr = 0;
                m_rd = 0;
            end else begin
                if (pa) begin
                    void'(m_q.pop_front());
                    m_rd = (m_rd + 1) % DEPTH;
                end
                if (wa) begin
                    m_q.push_back(m_wr);
                    m_wr = (m_wr + 1) % DEPTH;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            bit pa;
            bit wa;
            pa = f_pop_ok();
            wa = f_push_ok();
            chk("wr_en", wr_en, wa);
            chk("rd_en", rd_en, pa);
            chk("cnt_e", cnt_e, pa ^ wa);
            chk("cnt_d", cnt_d, pa && !wa);
            chk("wr_addr", wr_addr, m_wr);
            chk("rd_addr", rd_addr, m_rd);
            if (m_q.size() > 0) chk("rd_addr_head", rd_addr, m_q[0]);
            chk("count", count, m_q.size());
            chk("full", full, m_q.size() == DEPTH);
            chk("empty", empty, m_q.size() == 0);
            chk("almost_full", almost_full, m_q.size() >= AF);
            chk("almost_empty", almost_empty, m_q.size() <= AE);
            chk("rd_valid", rd_valid, m_rdv);
            chk("overflow", overflow, m_ovf);
            chk("underflow", underflow, m_udf);
        end
    end

    task automatic drive(input bit p, input bit q, input bit c);
        push  = p;
        pop   = q;
        clear = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wrap pattern: {push, pop} per cycle; six of each, ends empty with both pointers at 2.
    localparam logic [23:0] WRAP_PAT = 24'b10_10_01_10_01_10_01_01_10_10_01_01;
    localparam logic [31:0] MIX_PAT  = 32'b11_10_10_11_01_10_10_10_10_11_11_01_01_01_01_00;

    initial begin
        logic [23:0] wp;
        logic [31:0] mp;
        #1 cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_ae", almost_empty, 1);

        // Fill from empty.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            chk("fill_wr_addr", wr_addr, i);
            chk("fill_wr_en", wr_en, 1);
            tick();
            chk("fill_count", count, i + 1);
            chk("fill_af", almost_full, (i + 1) >= 3);
        end
        chk("fill_full", full, 1);

        // Push to full queue alone is rejected, overflow pulses once.
        drive(1'b1, 1'b0, 1'b0);
        chk("ovf_wr_en", wr_en, 0);
        tick();
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count", count, 4);
        drive(1'b0, 1'b0, 1'b0);
        tick();
        chk("ovf_gone", overflow, 0);

        // Push and pop together on full queue.
        drive(1'b1, 1'b1, 1'b0);
        chk("pp_wr_en", wr_en, 1);
        chk("pp_rd_en", rd_en, 1);
        chk("pp_cnt_e", cnt_e, 0);
        tick();
        chk("pp_count", count, 4);
        chk("pp_wr_addr", wr_addr, 1);
        chk("pp_rd_addr", rd_addr, 1);

        // Drain four entries.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            chk("drain_rd_addr", rd_addr, (i + 1) % 4);
            chk("drain_cnt_e", cnt_e, 1);
            chk("drain_cnt_d", cnt_d, 1);
            tick();
            chk("drain_rd_valid", rd_valid, 1);
            chk("drain_count", count, 3 - i);
        end
        chk("drain_empty", empty, 1);
        drive(1'b0, 1'b1, 1'b0);
        chk("udf_rd_en", rd_en, 0);
        tick();
        chk("udf_pulse", underflow, 1);
        chk("udf_rd_valid", rd_valid, 0);
        drive(1'b0, 1'b0, 1'b0);
        tick();
        chk("udf_gone", underflow, 0);

        // Flush on empty to restart pointers, then interleaved wrap.
        drive(1'b0, 1'b0, 1'b1);
        tick();
        chk("flush_wr_addr", wr_addr, 0);
        wp = WRAP_PAT;
        for (int i = 0; i < 12; i++) begin
            drive(wp[23], wp[22], 1'b0);
            wp = wp << 2;
            tick();
            chk("wrap_count_le4", count <= 3'd4, 1);
        end
        chk("wrap_count", count, 0);
        chk("wrap_wr_addr", wr_addr, 2);
        chk("wrap_rd_addr", rd_addr, 2);

        // Push and pop on empty: no bypass.
        drive(1'b1, 1'b1, 1'b0);
        chk("ep_wr_en", wr_en, 1);
        chk("ep_rd_en", rd_en, 0);
        chk("ep_cnt_e", cnt_e, 1);
        chk("ep_cnt_d", cnt_d, 0);
        tick();
        chk("ep_underflow", underflow, 1);
        chk("ep_count", count, 1);

        // Clear at count 3 with push and pop asserted.
        drive(1'b1, 1'b0, 1'b0);
        tick();
        tick();
        chk("pre_clr_count", count, 3);
        drive(1'b1, 1'b1, 1'b1);
        chk("clr_wr_en", wr_en, 0);
        chk("clr_rd_en", rd_en, 0);
        chk("clr_cnt_e", cnt_e, 0);
        tick();
        chk("clr_count", count, 0);
        chk("clr_empty", empty, 1);
        chk("clr_wr_addr", wr_addr, 0);
        chk("clr_rd_addr", rd_addr, 0);
        chk("clr_ovf", overflow, 0);
        chk("clr_udf", underflow, 0);
        chk("clr_rd_valid", rd_valid, 0);

        // Asynchronous reset in the middle of a burst.
        drive(1'b1, 1'b0, 1'b0);
        tick();
        tick();
        chk("burst_count", count, 2);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_wr_en", wr_en, 0);
        chk("arst_cnt_e", cnt_e, 0);
        chk("arst_wr_addr", wr_addr, 0);
        chk("arst_ae", almost_empty, 1);
        tick();
        tick();
        #1 reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        tick();

        // Mixed traffic checked by the model only.
        mp = MIX_PAT;
        for (int i = 0; i < 16; i++) begin
            drive(mp[31], mp[30], 1'b0);
            mp = mp << 2;
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
        tick();
        tick();

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
